// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
// Two-requester round-robin front end for a shared 8x8 sequential Booth core.
// A grant is decided in IDLE, announced with a one-cycle registered reqX_ready
// pulse, and then the core is sequenced LOAD -> (OPERATE, SHIFT) x ITERATIONS
// -> CAPTURE -> RESPOND. The captured product is held in RESPOND until the
// owning requester consumes it with rsp_ready.
module booth_mult_arbiter #(
    parameter int ITERATIONS = 8
) (
    input  logic        clk,
    input  logic        Reset,

    input  logic        req0_valid,
    input  logic [7:0]  req0_m,
    input  logic [7:0]  req0_n,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [7:0]  req1_m,
    input  logic [7:0]  req1_n,
    output logic        req1_ready,

    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp_ready,
    output logic [16:0] rsp_product,

    output logic [7:0]  mul_m,
    output logic [7:0]  mul_n,
    output logic        mul_load,
    output logic        mul_operate,
    output logic        mul_shift,
    output logic        mul_reset,
    input  logic [16:0] mul_product,

    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OPERATE,
        SHIFT,
        CAPTURE,
        RESPOND
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [3:0]  count;
    logic [3:0]  count_inc;
    logic        last_grant;
    logic        rst_q1;
    logic        rst_q2;

    logic        grant_pending;
    logic        take_grant;
    logic        win;

    logic        load_d;
    logic        operate_d;
    logic        shift_d;
    logic        busy_d;
    logic        rsp0_d;
    logic        rsp1_d;

    // A decision has been made and its ready pulse is on the wire this cycle.
    assign grant_pending = req0_ready | req1_ready;
    // Grants are taken only from a quiet IDLE with the core out of reset.
    assign take_grant    = (state == IDLE) && !grant_pending && !mul_reset
                           && (req0_valid || req1_valid);
    assign count_inc     = count + 4'd1;
    // The core reset covers every cycle Reset was sampled high plus one more.
    assign mul_reset     = rst_q1 | rst_q2;

    // Round-robin pick: a lone requester always wins, a tie goes to the other one.
    always_comb begin
        win = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    // Stretch the sampled reset by one cycle for the core.
    // NOTE: this pipeline deliberately has no reset branch; it is the reset history itself.
    always_ff @(posedge clk) begin
        rst_q1 <= Reset;
        rst_q2 <= rst_q1;
    end

    // State register and registered Moore outputs.
    // NOTE: every flop here uses <= so all registers see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            mul_load    <= 1'b0;
            mul_operate <= 1'b0;
            mul_shift   <= 1'b0;
            busy        <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
        end else begin
            state       <= next_state;
            mul_load    <= load_d;
            mul_operate <= operate_d;
            mul_shift   <= shift_d;
            busy        <= busy_d;
            rsp0_valid  <= rsp0_d;
            rsp1_valid  <= rsp1_d;
        end
    end

    // Next-state logic for the job sequence.
    // NOTE: next_state defaults to state first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_pending) next_state = LOAD;
            LOAD:    next_state = OPERATE;
            OPERATE: next_state = SHIFT;
            SHIFT:   next_state = (count_inc < 4'(ITERATIONS)) ? OPERATE : CAPTURE;
            CAPTURE: next_state = RESPOND;
            RESPOND: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so strobes line up with their state.
    always_comb begin
        load_d    = (next_state == LOAD);
        operate_d = (next_state == OPERATE);
        shift_d   = (next_state == SHIFT);
        busy_d    = (next_state != IDLE);
        rsp0_d    = (next_state == RESPOND) && !grant_id;
        rsp1_d    = (next_state == RESPOND) &&  grant_id;
    end

    // Grant bookkeeping, operand latch, iteration counter and result capture.
    always_ff @(posedge clk) begin
        if (Reset) begin
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            mul_m       <= '0;
            mul_n       <= '0;
            count       <= '0;
            rsp_product <= '0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (take_grant) begin
                        grant_id   <= win;
                        last_grant <= win;
                        mul_m      <= win ? req1_m : req0_m;
                        mul_n      <= win ? req1_n : req0_n;
                        req0_ready <= ~win;
                        req1_ready <= win;
                    end
                end
                SHIFT:   count <= count_inc;
                CAPTURE: rsp_product <= mul_product;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter
// Self-checking bench: a timeline model (cycle offset since the accept pulse)
// predicts every output each cycle; a bench-side Booth core only returns the
// true product after exactly one load and eight operate/shift strobes.
module tb_booth_mult_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_m, req0_n, req1_m, req1_n;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp_ready;
    logic [16:0] rsp_product;
    logic [7:0]  mul_m, mul_n;
    logic        mul_load, mul_operate, mul_shift, mul_reset;
    logic [16:0] core_prod = '0;
    logic        busy, grant_id;

    always #5 clk = ~clk;

    booth_mult_arbiter #(.ITERATIONS(8)) dut (
        .clk(clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_m(req0_m), .req0_n(req0_n), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_m(req1_m), .req1_n(req1_n), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product),
        .mul_m(mul_m), .mul_n(mul_n), .mul_load(mul_load), .mul_operate(mul_operate),
        .mul_shift(mul_shift), .mul_reset(mul_reset), .mul_product(core_prod),
        .busy(busy), .grant_id(grant_id)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int jobs_done = 0;

    // Reference model state: k is the offset of the current cycle from the accept pulse.
    int          k = -1;
    bit          last = 1'b1;
    bit          owner = 1'b0;
    logic [7:0]  mm = '0, nn = '0;
    logic [16:0] exp_prod = '0;
    bit          rq1 = 1'b0, rq2 = 1'b0;
    bit          model_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] sprod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return p[16:0];
    endfunction

    // Model update at each active edge from the inputs sampled there.
    initial begin : model
        bit mres_cur;
        bit w;
        forever begin
            @(posedge clk);
            cyc++;
            mres_cur = rq1 | rq2;
            rq2 = rq1;
            rq1 = Reset;
            if (Reset) begin
                k = -1; last = 1'b1; owner = 1'b0; mm = '0; nn = '0; exp_prod = '0;
                model_en = 1'b1;
            end else if (k == -1) begin
                if (!mres_cur && (req0_valid || req1_valid)) begin
                    w = (req0_valid && req1_valid) ? ~last : req1_valid;
                    owner = w; last = w;
                    mm = w ? req1_m : req0_m;
                    nn = w ? req1_n : req0_n;
                    k = 0;
                end
            end else if (k >= 19) begin
                if (rsp_ready) k = -1; else k++;
            end else begin
                if (k == 18) exp_prod = sprod(mm, nn);
                k++;
            end
        end
    end

    // Bench-side core: correct product only after 1 load + 8 operate + 8 shift.
    initial begin : core
        int c_op, c_sh;
        logic [7:0] a, b;
        c_op = 0; c_sh = 0; a = '0; b = '0;
        forever begin
            @(negedge clk);
            if (mul_reset === 1'b1) begin
                c_op = 0; c_sh = 0; core_prod = '0;
            end else begin
                if (mul_load === 1'b1) begin c_op = 0; c_sh = 0; a = mul_m; b = mul_n; end
                if (mul_operate === 1'b1) c_op++;
                if (mul_shift === 1'b1) c_sh++;
                core_prod = (c_op == 8 && c_sh == 8) ? sprod(a, b) : 17'h15555;
            end
        end
    end

    // Per-cycle comparison against the model, plus per-job strobe audit.
    initial begin : compare
        logic [10:0] e, a;
        int n_load, n_op, n_sh;
        n_load = 0; n_op = 0; n_sh = 0;
        forever begin
            @(negedge clk);
            if (model_en) begin
                e = {(k == 0) && !owner, (k == 0) && owner, k == 1,
                     (k >= 2) && (k <= 17) && (k % 2 == 0),
                     (k >= 3) && (k <= 17) && (k % 2 == 1),
                     k >= 1, (k >= 19) && !owner, (k >= 19) && owner,
                     owner, rq1 | rq2, 1'b0};
                a = {req0_ready, req1_ready, mul_load, mul_operate, mul_shift,
                     busy, rsp0_valid, rsp1_valid, grant_id, mul_reset, 1'b0};
                check("outputs{r0,r1,ld,op,sh,busy,v0,v1,gid,mrst}", {21'b0, a}, {21'b0, e});
                check("operands{m,n}", {16'b0, mul_m, mul_n}, {16'b0, mm, nn});
                check("rsp_product", {15'b0, rsp_product}, {15'b0, exp_prod});
                if (mul_reset) begin
                    n_load = 0; n_op = 0; n_sh = 0;
                end else begin
                    n_load += int'(mul_load);
                    n_op   += int'(mul_operate);
                    n_sh   += int'(mul_shift);
                    if ((rsp0_valid || rsp1_valid) && rsp_ready) begin
                        check("job_load_count", n_load, 1);
                        check("job_operate_count", n_op, 8);
                        check("job_shift_count", n_sh, 8);
                        n_load = 0; n_op = 0; n_sh = 0;
                        jobs_done++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic bit sig(input int which);
        case (which)
            0: return req0_ready;
            1: return req1_ready;
            2: return rsp0_valid;
            3: return rsp1_valid;
            4: return mul_load;
            5: return req0_ready | req1_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a signal; the first sample is the next falling edge.
    task automatic wait_for(input int which, input string name, output int at);
        at = -1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (sig(which)) begin
                at = cyc;
                break;
            end
        end
        check({name, "_seen"}, at >= 0, 1);
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) tick();
        Reset = 1'b0;
    endtask

    function automatic logic [7:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'h00;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int t0, t1, t2, t3, sh_cnt, sh_at, start;
        bit s0, s1;
        Reset = 1'b1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_m = '0; req0_n = '0; req1_m = '0; req1_n = '0;
        do_reset(3);

        // Single job: 100 * -99 = -9900 = 0x1D954.
        req0_valid = 1; req0_m = 8'd100; req0_n = 8'h9D; rsp_ready = 1;
        wait_for(0, "single_ready", t0);
        tick(); req0_valid = 0;
        wait_for(4, "single_load", t1);
        check("single_load_at_T+1", t1 - t0, 1);
        wait_for(2, "single_rsp0", t2);
        check("single_rsp_at_T+19", t2 - t0, 19);
        check("single_product", {15'b0, rsp_product}, 32'h1D954);
        check("single_rsp1_low", rsp1_valid, 0);
        @(negedge clk);
        check("single_rsp0_drops", rsp0_valid, 0);
        check("single_idle", busy, 0);

        // Tie from reset: req0, then req1 at +21, then req0 again.
        tick();
        req0_valid = 1; req0_m = 8'd3;   req0_n = 8'd5;
        req1_valid = 1; req1_m = 8'hF9;  req1_n = 8'd9;
        do_reset(2);
        wait_for(5, "tie1_ready", t0);
        check("tie1_winner_req0", {req0_ready, req1_ready}, 2'b10);
        tick(); req0_valid = 0;
        wait_for(5, "tie2_ready", t1);
        check("tie2_winner_req1", {req0_ready, req1_ready}, 2'b01);
        check("tie2_gap_21", t1 - t0, 21);
        tick(); req1_valid = 0;
        wait_for(3, "tie2_rsp1", t2);
        tick();
        req0_valid = 1; req0_m = 8'd11; req0_n = 8'd12;
        req1_valid = 1; req1_m = 8'd13; req1_n = 8'd14;
        wait_for(5, "tie3_ready", t3);
        check("tie3_winner_req0", {req0_ready, req1_ready}, 2'b10);
        tick(); req0_valid = 0;
        wait_for(1, "tie4_ready", t3);
        tick(); req1_valid = 0;
        wait_for(3, "tie4_rsp1", t3);
        tick();

        // Backpressure: -128 * -128 = 16384 held for 10 cycles.
        rsp_ready = 0;
        req1_valid = 1; req1_m = 8'h80; req1_n = 8'h80;
        wait_for(1, "bp_ready", t0);
        tick(); req1_valid = 0;
        wait_for(3, "bp_rsp1", t1);
        req0_valid = 1; req0_m = 8'd1; req0_n = 8'd1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_rsp1_held", rsp1_valid, 1);
            check("bp_product_held", {15'b0, rsp_product}, 32'h04000);
            check("bp_no_strobes", {mul_load, mul_operate, mul_shift}, 0);
            check("bp_req0_ready_low", req0_ready, 0);
        end
        tick(); rsp_ready = 1;
        @(negedge clk);
        check("bp_rsp1_until_ready", rsp1_valid, 1);
        @(negedge clk);
        check("bp_rsp1_drops", rsp1_valid, 0);
        wait_for(0, "bp_req0_ready", t2);
        tick(); req0_valid = 0;
        wait_for(2, "bp_req0_rsp", t2);
        check("bp_req0_product", {15'b0, rsp_product}, 32'h00001);
        tick();

        // Mid-job reset on the 4th SHIFT.
        req0_valid = 1; req0_m = 8'd55; req0_n = 8'hFD;
        wait_for(0, "mid_ready", t0);
        tick(); req0_valid = 0;
        sh_cnt = 0; sh_at = -1;
        for (int i = 0; i < 40 && sh_at < 0; i++) begin
            @(negedge clk);
            if (mul_shift) begin
                sh_cnt++;
                if (sh_cnt == 4) sh_at = cyc;
            end
        end
        check("mid_4th_shift_at_T+9", sh_at - t0, 9);
        Reset = 1'b1;
        tick(); Reset = 1'b0;
        @(negedge clk);
        check("mid_after_reset", {mul_load, mul_operate, mul_shift, busy, rsp0_valid, rsp1_valid, mul_reset}, 7'b0000001);
        @(negedge clk);
        check("mid_mul_reset_2nd", mul_reset, 1);
        @(negedge clk);
        check("mid_mul_reset_off", mul_reset, 0);
        check("mid_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        tick();
        req0_valid = 1; req0_m = 8'hFF; req0_n = 8'hFF;
        wait_for(0, "mid_fresh_ready", t1);
        tick(); req0_valid = 0;
        wait_for(2, "mid_fresh_rsp", t2);
        check("mid_fresh_product", {15'b0, rsp_product}, 32'h00001);
        tick();

        // Random traffic: 100 jobs with random backpressure and boundary operands.
        start = jobs_done;
        for (int c = 0; c < 20000 && (jobs_done - start) < 100; c++) begin
            @(negedge clk);
            s0 = req0_ready; s1 = req1_ready;
            tick();
            if (s0) req0_valid = 0;
            if (s1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 3) == 0) begin
                req0_valid = 1; req0_m = rnd_op(); req0_n = rnd_op();
            end
            if (!req1_valid && $urandom_range(0, 3) == 0) begin
                req1_valid = 1; req1_m = rnd_op(); req1_n = rnd_op();
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        check("random_100_jobs_done", (jobs_done - start) >= 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
